tlb_plru_nway: RTL and testbench
================================

Name: tlb_plru_nway

Overview:
- Parametrised set-associative TLB with PCID tagging, generalised from the fixed 8-way/8-set translation buffer.
- Adds:
  - arbitrary power-of-two way count with a generic tree-PLRU;
  - valid-bit-qualified hits;
  - invalid-first victim selection and in-place overwrite of duplicates;
  - a valid/ready lookup handshake;
  - per-PCID selective flush.
- Sits between the core address-generation stage and the page-table walker, which performs inserts on miss.

Parameters:
- SADDR, 32, address width.
- SPAGE, 12, page-offset width.
- NSET, 8, number of sets (power of two, ≥2).
- NWAY, 8, ways per set (power of two, ≥2).
- SPCID, 12, PCID width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  lookup request.
- req_ready  out  1  high when FSM is IDLE and no flush/insert is being accepted this cycle.
- req_va  in  SADDR  virtual address to translate.
- req_pcid  in  SPCID  PCID of request.
- resp_valid  out  1  one-cycle pulse carrying lookup result.
- resp_hit  out  1  valid with resp_valid; 1 = hit.
- resp_pa  out  SADDR  translated address; {entry PA, req_va[SPAGE-1:0]} on hit, 0 on miss.
- ins_valid  in  1  insert request (single-cycle pulse, accepted only in IDLE).
- ins_va  in  SADDR  virtual address of new PTE.
- ins_pa  in  SADDR  physical address of new PTE; low SPAGE bits ignored.
- ins_pcid  in  SPCID  PCID of new PTE.
- flush_all  in  1  invalidate every entry.
- flush_pcid_valid  in  1  invalidate entries whose PCID equals flush_pcid.
- flush_pcid  in  SPCID  PCID to flush.
- busy  out  1  high while FLUSH sweep runs.

Behaviour:
- Address split: set = va[SPAGE+log2(NSET)-1:SPAGE]; tag = va[SADDR-1:SPAGE+log2(NSET)].
- Entry = {valid, tag, pcid, pa[SADDR-1:SPAGE]}.
- Reset (async, rst_n=0):
  - all valid bits and PLRU bits 0; FSM=IDLE; flush counter 0;
  - resp_valid=0, resp_hit=0, resp_pa=0, busy=0, req_ready=0 while in reset.
  - Tag/PA storage need not be cleared.
- FSM states IDLE, LOOKUP, INSERT, FLUSH.
- Acceptance priority in IDLE: flush_all|flush_pcid_valid > ins_valid > req_valid.
- Requests arriving outside IDLE are dropped; the issuer must hold req_valid until req_ready handshake. ins_valid/flush are sampled in IDLE only.
- Lookup:
  - on req_valid&&req_ready, latch va/pcid; IDLE->LOOKUP.
  - In LOOKUP, compare all ways: hit = valid && tag== && pcid==.
  - Next edge: resp_valid=1 for exactly one cycle, result registered; return to IDLE. Latency 2 edges from acceptance to resp_valid visible.
  - Hit updates PLRU path of the hit way; miss leaves PLRU unchanged.
  - Multiple matching ways cannot occur (insert guarantees uniqueness).
- Insert:
  - IDLE->INSERT latches ins_*; one cycle in INSERT, then IDLE.
  - Way choice: existing matching (valid, tag, pcid) way if any (overwrite PA); else lowest-index invalid way; else PLRU victim.
  - Written way: valid=1; PLRU updated as an access. No response generated.
- PLRU:
  - NWAY-1 tree bits, node i children 2i+1 / 2i+2, leaves map left-to-right to ways 0..NWAY-1.
  - Bit 0 = victim in left subtree.
  - On access to way w, every node on w's path is set to point away from w.
  - Victim = follow bits from root.
- Flush:
  - IDLE->FLUSH latches mode (all or pcid); busy=1; counter sweeps sets 0..NSET-1, one set per cycle.
  - flush_all clears every valid bit and PLRU bits of the set.
  - pcid mode clears valid only where pcid matches; PLRU untouched.
  - After set NSET-1: counter=0, busy=0, IDLE. Duration exactly NSET cycles with busy high.
- Reset asserted mid-flush/insert aborts immediately; state returns to reset values.

Decomposition:
- Package tlb_pkg: FSM state encoding, derived widths (SET_W, TAG_W, PPN_W, ENTRY_W), entry field range macros, flush-mode constant.
- Sub-module tlb_plru_tree (parameter NWAY): combinational victim index from tree bits, and next-tree-bits given accessed way. Instantiated once, driven with the selected set's bits.

Test Plan:
- Reset then insert va=0x0001_2345, pa=0xABCD_E000, pcid=5; lookup va=0x0001_2FFF pcid=5 -> resp_hit=1, resp_pa=0xABCD_EFFF, resp_valid exactly one cycle, two edges after handshake.
- Same va, pcid=6 -> resp_hit=0, resp_pa=0. Re-insert same va/pcid=5 with pa=0x1111_1000 -> lookup returns 0x1111_1345; no other way in set 2 is consumed.
- Fill set 2 with eight distinct tags (ways 0..7 in order), then insert a ninth tag -> way 0 replaced: first tag misses, other seven hit. Before the ninth insert, touch way 0 by a lookup; way 4 is then replaced instead.
- Entries pcid 5 and 6 in sets 0 and 7; flush_pcid_valid=1, flush_pcid=5 -> busy high exactly 8 cycles, req_ready=0 during; then pcid 5 misses, pcid 6 hits.
- flush_all simultaneous with ins_valid and req_valid -> flush taken, insert and lookup ignored; all subsequent lookups miss.
- Deassert rst_n on the 3rd cycle of a flush -> busy=0, resp_valid=0 immediately; after release, all lookups miss and FSM accepts a request next cycle.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared definitions for the PCID-tagged set-associative TLB: FSM encoding,
// flush-mode constant and helpers deriving field widths from the parameters.
package tlb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_INSERT = 2'd2,
    ST_FLUSH  = 2'd3
  } tlb_state_e;

  localparam logic FLUSH_MODE_ALL  = 1'b1;
  localparam logic FLUSH_MODE_PCID = 1'b0;

  // Entry layout, MSB first: {valid, tag, pcid, ppn}
  function automatic int set_w(input int nset);
    return $clog2(nset);
  endfunction

  function automatic int tag_w(input int saddr, input int spage, input int nset);
    return saddr - spage - $clog2(nset);
  endfunction

  function automatic int ppn_w(input int saddr, input int spage);
    return saddr - spage;
  endfunction

  function automatic int entry_w(input int saddr, input int spage, input int nset,
                                 input int spcid);
    return 1 + tag_w(saddr, spage, nset) + spcid + ppn_w(saddr, spage);
  endfunction

  function automatic int entry_valid_bit(input int saddr, input int spage, input int nset,
                                         input int spcid);
    return entry_w(saddr, spage, nset, spcid) - 1;
  endfunction

endpackage

// File: rtl/tlb_plru_tree.sv
// Generic tree-PLRU: victim walk from the root and path update for an accessed way.
module tlb_plru_tree #(
  parameter int NWAY  = 8,
  parameter int WAY_W = $clog2(NWAY)
) (
  input  logic [NWAY-2:0]  tree,
  input  logic [WAY_W-1:0] acc_way,
  output logic [WAY_W-1:0] victim,
  output logic [NWAY-2:0]  tree_nxt
);

  int node;
  int idx;

  // A node bit of 0 steers the victim into the left subtree.
  always_comb begin
    victim = '0;
    node   = 0;
    for (int l = 0; l < WAY_W; l++) begin
      victim[WAY_W-1-l] = tree[node];
      node = 2 * node + 1 + (tree[node] ? 1 : 0);
    end
  end

  // Every node on the accessed path points to the opposite subtree.
  always_comb begin
    tree_nxt = tree;
    idx      = 0;
    for (int l = 0; l < WAY_W; l++) begin
      idx = (1 << l) - 1 + int'(acc_way >> (WAY_W - l));
      tree_nxt[idx] = ~acc_way[WAY_W-1-l];
    end
  end

endmodule

// File: rtl/tlb_plru_nway.sv
// N-way set-associative TLB with PCID tags, tree-PLRU replacement,
// valid/ready lookup, walker inserts and full / per-PCID flush sweeps.
module tlb_plru_nway
  import tlb_pkg::*;
#(
  parameter int SADDR = 32,
  parameter int SPAGE = 12,
  parameter int NSET  = 8,
  parameter int NWAY  = 8,
  parameter int SPCID = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SADDR-1:0] req_va,
  input  logic [SPCID-1:0] req_pcid,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [SADDR-1:0] resp_pa,
  input  logic             ins_valid,
  input  logic [SADDR-1:0] ins_va,
  input  logic [SADDR-1:0] ins_pa,
  input  logic [SPCID-1:0] ins_pcid,
  input  logic             flush_all,
  input  logic             flush_pcid_valid,
  input  logic [SPCID-1:0] flush_pcid,
  output logic             busy
);

  localparam int SET_W = set_w(NSET);
  localparam int TAG_W = tag_w(SADDR, SPAGE, NSET);
  localparam int PPN_W = ppn_w(SADDR, SPAGE);
  localparam int WAY_W = $clog2(NWAY);

  tlb_state_e state, state_nxt;

  logic [SADDR-1:0] lat_va;
  logic [SPCID-1:0] lat_pcid;
  logic [PPN_W-1:0] lat_ppn;
  logic             flush_mode;
  logic [SPCID-1:0] flush_pcid_q;
  logic [SET_W-1:0] fcnt;

  logic [NSET-1:0][NWAY-1:0]             vld;
  logic [NSET-1:0][NWAY-2:0]             plru;
  logic [NSET-1:0][NWAY-1:0][TAG_W-1:0]  tag_mem;
  logic [NSET-1:0][NWAY-1:0][SPCID-1:0]  pcid_mem;
  logic [NSET-1:0][NWAY-1:0][PPN_W-1:0]  ppn_mem;

  logic [SET_W-1:0] lat_set;
  logic [TAG_W-1:0] lat_tag;
  logic [NWAY-1:0]  match;
  logic             hit, any_inv;
  logic [WAY_W-1:0] hit_way, inv_way, victim, acc_way;
  logic [NWAY-2:0]  tree_nxt;
  logic             flush_req;
  logic             unused_pa_ofs;

  assign flush_req     = flush_all | flush_pcid_valid;
  assign req_ready     = rst_n && (state == ST_IDLE) && !flush_req && !ins_valid;
  assign busy          = (state == ST_FLUSH);
  assign lat_set       = lat_va[SPAGE +: SET_W];
  assign lat_tag       = lat_va[SADDR-1 -: TAG_W];
  assign unused_pa_ofs = ^ins_pa[SPAGE-1:0];

  for (genvar w = 0; w < NWAY; w++) begin : g_cmp
    assign match[w] = vld[lat_set][w] && (tag_mem[lat_set][w] == lat_tag)
                      && (pcid_mem[lat_set][w] == lat_pcid);
  end

  // Descending scan leaves the lowest matching / invalid index selected.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int w = NWAY - 1; w >= 0; w--) begin
      if (match[w]) hit_way = WAY_W'(w);
      if (!vld[lat_set][w]) begin
        inv_way = WAY_W'(w);
        any_inv = 1'b1;
      end
    end
  end

  assign hit     = |match;
  assign acc_way = (state == ST_INSERT && !hit) ? (any_inv ? inv_way : victim) : hit_way;

  tlb_plru_tree #(.NWAY(NWAY)) u_plru (
    .tree     (plru[lat_set]),
    .acc_way  (acc_way),
    .victim   (victim),
    .tree_nxt (tree_nxt)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (flush_req)      state_nxt = ST_FLUSH;
        else if (ins_valid) state_nxt = ST_INSERT;
        else if (req_valid) state_nxt = ST_LOOKUP;
      end
      ST_LOOKUP, ST_INSERT: state_nxt = ST_IDLE;
      ST_FLUSH: if (fcnt == SET_W'(NSET - 1)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      fcnt       <= '0;
      vld        <= '0;
      plru       <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_pa    <= '0;
    end else begin
      state      <= state_nxt;
      resp_valid <= (state == ST_LOOKUP);
      unique case (state)
        ST_LOOKUP: begin
          resp_hit <= hit;
          resp_pa  <= hit ? {ppn_mem[lat_set][hit_way], lat_va[SPAGE-1:0]} : '0;
          if (hit) plru[lat_set] <= tree_nxt;
        end
        ST_INSERT: begin
          vld[lat_set][acc_way] <= 1'b1;
          plru[lat_set]         <= tree_nxt;
        end
        ST_FLUSH: begin
          for (int w = 0; w < NWAY; w++)
            if (flush_mode == FLUSH_MODE_ALL || pcid_mem[fcnt][w] == flush_pcid_q)
              vld[fcnt][w] <= 1'b0;
          if (flush_mode == FLUSH_MODE_ALL) plru[fcnt] <= '0;
          fcnt <= (fcnt == SET_W'(NSET - 1)) ? '0 : fcnt + SET_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Datapath latches and entry payload need no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE) begin
      if (flush_req) begin
        flush_mode   <= flush_all ? FLUSH_MODE_ALL : FLUSH_MODE_PCID;
        flush_pcid_q <= flush_pcid;
      end else if (ins_valid) begin
        lat_va   <= ins_va;
        lat_pcid <= ins_pcid;
        lat_ppn  <= ins_pa[SADDR-1:SPAGE];
      end else if (req_valid) begin
        lat_va   <= req_va;
        lat_pcid <= req_pcid;
      end
    end
    if (state == ST_INSERT) begin
      tag_mem[lat_set][acc_way]  <= lat_tag;
      pcid_mem[lat_set][acc_way] <= lat_pcid;
      ppn_mem[lat_set][acc_way]  <= lat_ppn;
    end
  end

endmodule

// File: tb/tb_tlb_plru_nway.sv
// Self-checking bench for tlb_plru_nway: table-driven lookups against a
// response scoreboard, plus fill/replace, flush and mid-flush reset sequences.
module tb_tlb_plru_nway;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_va;
  logic [11:0] req_pcid;
  logic        resp_valid, resp_hit;
  logic [31:0] resp_pa;
  logic        ins_valid;
  logic [31:0] ins_va, ins_pa;
  logic [11:0] ins_pcid;
  logic        flush_all, flush_pcid_valid;
  logic [11:0] flush_pcid;
  logic        busy;

  tlb_plru_nway dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va), .req_pcid(req_pcid),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_pa(resp_pa),
    .ins_valid(ins_valid), .ins_va(ins_va), .ins_pa(ins_pa), .ins_pcid(ins_pcid),
    .flush_all(flush_all), .flush_pcid_valid(flush_pcid_valid), .flush_pcid(flush_pcid),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] va;
    logic [11:0] pcid;
    logic        hit;
    logic [31:0] pa;
  } lk_vec_t;

  typedef struct packed {
    logic        hit;
    logic [31:0] pa;
  } exp_t;

  exp_t    sb_q[$];
  lk_vec_t tbl[$];
  int      checks = 0;
  int      errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && resp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual hit=%0d pa=0x%0h expected no response",
                 resp_hit, resp_pa);
      end else begin
        e = sb_q.pop_front();
        chk("resp_hit", {31'b0, resp_hit}, {31'b0, e.hit});
        chk("resp_pa", resp_pa, e.pa);
      end
    end
  end

  function automatic logic [31:0] mkva(input int tag, input int set);
    return (32'(tag) << 15) | (32'(set) << 12);
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk({name, "_ready_timeout"}, {31'b0, req_ready}, 32'd1);
  endtask

  task automatic lookup(input logic [31:0] va, input logic [11:0] pcid,
                        input logic hit, input logic [31:0] pa);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_va    = va;
    req_pcid  = pcid;
    #1;
    wait_ready("lookup");
    e.hit = hit;
    e.pa  = pa;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    chk("lat_edge1", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("lat_edge2", {31'b0, resp_valid}, 32'd1);
    @(negedge clk);
    chk("pulse_width", {31'b0, resp_valid}, 32'd0);
  endtask

  task automatic insert(input logic [31:0] va, input logic [31:0] pa, input logic [11:0] pcid);
    @(negedge clk);
    wait_ready("insert");
    ins_valid = 1'b1;
    ins_va    = va;
    ins_pa    = pa;
    ins_pcid  = pcid;
    @(negedge clk);
    ins_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) lookup(tbl[i].va, tbl[i].pcid, tbl[i].hit, tbl[i].pa);
    tbl.delete();
  endtask

  task automatic count_busy(input string name, output int n, output int rdy_bad);
    n = 0;
    rdy_bad = 0;
    while (busy && n < 50) begin
      if (req_ready) rdy_bad++;
      n++;
      @(negedge clk);
    end
    chk(name, n, 32'd8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad;
    logic [31:0] pa_of [0:10];
    rst_n = 1'b0; req_valid = 0; req_va = 0; req_pcid = 0;
    ins_valid = 0; ins_va = 0; ins_pa = 0; ins_pcid = 0;
    flush_all = 0; flush_pcid_valid = 0; flush_pcid = 0;
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_hit", {31'b0, resp_hit}, 32'd0);
    chk("rst_resp_pa", resp_pa, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

    // Basic hit, PCID mismatch, in-place overwrite
    insert(32'h0001_2345, 32'hABCD_E000, 12'd5);
    tbl.push_back('{32'h0001_2FFF, 12'd5, 1'b1, 32'hABCD_EFFF});
    tbl.push_back('{32'h0001_2FFF, 12'd6, 1'b0, 32'h0});
    run_tbl();
    insert(32'h0001_2345, 32'h1111_1000, 12'd5);
    tbl.push_back('{32'h0001_2345, 12'd5, 1'b1, 32'h1111_1345});
    run_tbl();

    // Fill set 2 with tags 3..9 behind tag 2; ninth tag 10 evicts way 0 (tag 2)
    pa_of[2] = 32'h1111_1000;
    for (int t = 3; t <= 10; t++) begin
      pa_of[t] = 32'h5000_0000 + 32'(t) * 32'h1000;
      insert(mkva(t, 2), pa_of[t], 12'd5);
    end
    tbl.push_back('{mkva(2, 2) | 32'h0AB, 12'd5, 1'b0, 32'h0});
    for (int t = 3; t <= 10; t++)
      tbl.push_back('{mkva(t, 2) | 32'h0AB, 12'd5, 1'b1, pa_of[t] | 32'h0AB});
    run_tbl();

    // flush_all wins over simultaneous insert and lookup
    @(negedge clk);
    wait_ready("flush_all");
    flush_all = 1; ins_valid = 1; ins_va = mkva(20, 3); ins_pa = 32'h7700_0000; ins_pcid = 5;
    req_valid = 1; req_va = mkva(20, 3); req_pcid = 5;
    #1;
    chk("ready_low_on_flush", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    flush_all = 0; ins_valid = 0; req_valid = 0;
    count_busy("flush_all_len", n, bad);
    chk("flush_all_ready_low", bad, 32'd0);
    tbl.push_back('{mkva(20, 3), 12'd5, 1'b0, 32'h0});
    tbl.push_back('{mkva(3, 2), 12'd5, 1'b0, 32'h0});
    tbl.push_back('{mkva(10, 2), 12'd5, 1'b0, 32'h0});
    run_tbl();

    // Refill set 2, touch way 0, ninth insert must evict way 4 (tag 6)
    for (int t = 2; t <= 9; t++) begin
      pa_of[t] = 32'h6000_0000 + 32'(t) * 32'h1000;
      insert(mkva(t, 2), pa_of[t], 12'd5);
    end
    lookup(mkva(2, 2), 12'd5, 1'b1, pa_of[2]);
    pa_of[10] = 32'h6AAA_A000;
    insert(mkva(10, 2), pa_of[10], 12'd5);
    for (int t = 2; t <= 10; t++)
      tbl.push_back('{mkva(t, 2), 12'd5, (t != 6), (t != 6) ? pa_of[t] : 32'h0});
    run_tbl();

    // Per-PCID flush: pcid 5 gone, pcid 6 survives in sets 0 and 7
    insert(mkva(30, 0), 32'hA000_0000, 12'd5);
    insert(mkva(30, 0), 32'hB000_0000, 12'd6);
    insert(mkva(31, 7), 32'hA100_0000, 12'd5);
    insert(mkva(31, 7), 32'hB100_0000, 12'd6);
    @(negedge clk);
    wait_ready("flush_pcid");
    flush_pcid_valid = 1; flush_pcid = 12'd5;
    @(negedge clk);
    flush_pcid_valid = 0;
    count_busy("flush_pcid_len", n, bad);
    chk("flush_pcid_ready_low", bad, 32'd0);
    tbl.push_back('{mkva(30, 0) | 32'h123, 12'd5, 1'b0, 32'h0});
    tbl.push_back('{mkva(30, 0) | 32'h123, 12'd6, 1'b1, 32'hB000_0123});
    tbl.push_back('{mkva(31, 7), 12'd5, 1'b0, 32'h0});
    tbl.push_back('{mkva(31, 7), 12'd6, 1'b1, 32'hB100_0000});
    tbl.push_back('{mkva(9, 2), 12'd5, 1'b0, 32'h0});
    run_tbl();

    // Reset on the third flush cycle aborts the sweep and clears entries
    insert(mkva(40, 4), 32'hC000_0000, 12'd7);
    lookup(mkva(40, 4), 12'd7, 1'b1, 32'hC000_0000);
    @(negedge clk);
    wait_ready("flush_rst");
    flush_pcid_valid = 1; flush_pcid = 12'd9;
    @(negedge clk);
    flush_pcid_valid = 0;
    chk("flush_started", {31'b0, busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mid_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", {31'b0, req_ready}, 32'd1);
    tbl.push_back('{mkva(40, 4), 12'd7, 1'b0, 32'h0});
    tbl.push_back('{mkva(31, 7), 12'd6, 1'b0, 32'h0});
    run_tbl();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
